// File: rtl/serial_word_receiver.sv
// Serial word receiver: frames start(0) + WIDTH data bits LSB first + stop(1),
// delivers each word through a valid/ready register and pulses frame_error /
// overrun. The shift register and output register are independent so a new
// frame can be received while the previous word is still waiting downstream.
module serial_word_receiver #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             serial_data,
  input  logic             serial_enable,
  input  logic             word_ready,
  output logic [WIDTH-1:0] word_data,
  output logic             word_valid,
  output logic             frame_error,
  output logic             overrun,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
  logic             busy_q, busy_d;

  // One-hot decode of the bit counter: selects which shift bit the current
  // data bit lands in (avoids indexing with a counter wider than the index).
  logic [WIDTH-1:0] bit_sel;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit_sel
      assign bit_sel[gi] = (cnt_q == CW'(gi));
    end
  endgenerate

  logic handshake;
  assign handshake = valid_q && word_ready;

  // Next-state logic: FSM advance on strobes, commit/overrun, handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    // A consumed word clears valid; a commit below in the same edge re-sets it.
    if (handshake) begin
      valid_d = 1'b0;
    end

    if (serial_enable) begin
      case (state_q)
        IDLE: begin
          if (!serial_data) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          shift_d = (shift_q & ~bit_sel) | (bit_sel & {WIDTH{serial_data}});
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = STOP;
          end
        end
        STOP: begin
          state_d = IDLE;
          if (serial_data) begin
            if (!valid_q || handshake) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  assign word_data   = data_q;
  assign word_valid  = valid_q;
  assign frame_error = ferr_q;
  assign overrun     = ovr_q;
  assign busy        = busy_q;

endmodule
